// File: rtl/alu_seq_pkg.sv
// Shared function codes, sequencer state encoding and legality check for the
// ALU/shifter/divider issue path.
package alu_seq_pkg;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_NOP  = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_HILO_WR  = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  function automatic logic is_legal_funct(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_DIVU, F_MFHI, F_MFLO: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable down-counter; done flags the final cycle (count value 1) of a
// timed state.
module alu_seq_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller for the 32-bit ALU/shifter/divider: one request at a time,
// timed function-code issue, one response per request, HI/LO and div-by-zero guards.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT    = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  dbg_state,
  output logic        dbg_hilo_valid
);

  localparam int MAX_CYC = (ALU_LAT > DIV_CYCLES) ? ALU_LAT : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_e      state_q;
  logic [5:0]  alu_signal_q;
  logic [31:0] a_q, b_q, rsp_data_q;
  logic        rsp_err_q, hilo_valid_q;

  logic          accept, is_div, req_err;
  logic          tmr_load, tmr_count, tmr_done;
  logic [CW-1:0] tmr_val;

  // Rejected requests skip the datapath entirely and answer the next cycle.
  assign accept  = req_valid && (state_q == S_IDLE);
  assign is_div  = (req_funct == F_DIVU);
  assign req_err = !is_legal_funct(req_funct)
                || (is_div && (req_b == 32'd0))
                || (((req_funct == F_MFHI) || (req_funct == F_MFLO)) && !hilo_valid_q);

  assign tmr_load  = accept && !req_err;
  assign tmr_val   = is_div ? CW'(DIV_CYCLES) : CW'(ALU_LAT);
  assign tmr_count = (state_q == S_EXEC) || (state_q == S_DIV_WAIT);

  alu_seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      alu_signal_q <= F_NOP;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      hilo_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q <= req_a;
            b_q <= req_b;
            if (req_err) begin
              state_q    <= S_RESP;
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end else if (is_div) begin
              state_q      <= S_DIV_WAIT;
              alu_signal_q <= F_DIVU;
            end else begin
              state_q      <= S_EXEC;
              alu_signal_q <= req_funct;
            end
          end
        end
        S_EXEC: begin
          if (tmr_done) begin
            state_q      <= S_RESP;
            alu_signal_q <= F_NOP;
            rsp_data_q   <= alu_result;
            rsp_err_q    <= 1'b0;
          end
        end
        S_DIV_WAIT: begin
          if (tmr_done) begin
            state_q      <= S_HILO_WR;
            alu_signal_q <= F_NOP;
          end
        end
        S_HILO_WR: begin
          state_q      <= S_RESP;
          hilo_valid_q <= 1'b1;
          rsp_data_q   <= '0;
          rsp_err_q    <= 1'b0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q    <= S_IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign alu_signal     = alu_signal_q;
  assign alu_dataA      = a_q;
  assign alu_dataB      = b_q;
  assign dbg_state      = state_q;
  assign dbg_hilo_valid = hilo_valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer with a registered-control
// datapath model and a spec-level response reference.
module tb_alu_op_sequencer;

  localparam int ALU_LAT    = 2;
  localparam int DIV_CYCLES = 32;
  localparam int W          = 65;   // {err, data[31:0], latency[15:0], issue_cycles[15:0]}
  localparam logic [5:0] NOP = 6'h3F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_funct = 6'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic [5:0]  alu_signal;
  logic [31:0] alu_dataA, alu_dataB, alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;
  logic [2:0]  dbg_state;
  logic        dbg_hilo_valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic        ref_hv = 1'b0;
  logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;

  logic [5:0]  legal_f [9] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd27, 6'd16, 6'd18};

  // Clock
  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LAT(ALU_LAT), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct      (req_funct),
    .req_a          (req_a),
    .req_b          (req_b),
    .alu_signal     (alu_signal),
    .alu_dataA      (alu_dataA),
    .alu_dataB      (alu_dataB),
    .alu_result     (alu_result),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .dbg_hilo_valid (dbg_hilo_valid)
  );

  // Datapath model: function code goes through one control register before the
  // combinational result settles, so the result is only right on the 2nd cycle.
  logic [5:0]  sig_d1 = 6'h3F;
  logic [31:0] dp_hi = 32'd0, dp_lo = 32'd0;

  always @(posedge clk) begin
    sig_d1 <= alu_signal;
    if (alu_signal == 6'd27 && alu_dataB != 32'd0) begin
      dp_hi <= alu_dataA % alu_dataB;
      dp_lo <= alu_dataA / alu_dataB;
    end
  end

  always_comb begin
    alu_result = 32'hBAD0_BAD0;
    case (sig_d1)
      6'd36: alu_result = alu_dataA & alu_dataB;
      6'd37: alu_result = alu_dataA | alu_dataB;
      6'd32: alu_result = alu_dataA + alu_dataB;
      6'd34: alu_result = alu_dataA - alu_dataB;
      6'd42: alu_result = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
      6'd0:  alu_result = alu_dataB << alu_dataA[4:0];
      6'd16: alu_result = dp_hi;
      6'd18: alu_result = dp_lo;
      default: alu_result = 32'hBAD0_BAD0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_legal(input logic [5:0] f);
    for (int i = 0; i < 9; i++) if (legal_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: what software should see for one request, in arrival order.
  task automatic ref_predict(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic err;
    logic [31:0] d;
    int lat, sig;
    err = 1'b0;
    d   = 32'd0;
    case (f)
      6'd36: d = a & b;
      6'd37: d = a | b;
      6'd32: d = a + b;
      6'd34: d = a - b;
      6'd42: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd0:  d = b << a[4:0];
      6'd27: begin
        if (b == 32'd0) err = 1'b1;
        else begin
          ref_hi = a % b;
          ref_lo = a / b;
          ref_hv = 1'b1;
        end
      end
      6'd16: if (!ref_hv) err = 1'b1; else d = ref_hi;
      6'd18: if (!ref_hv) err = 1'b1; else d = ref_lo;
      default: err = 1'b1;
    endcase
    if (err) begin
      lat = 1; sig = 0;
    end else if (f == 6'd27) begin
      lat = DIV_CYCLES + 2; sig = DIV_CYCLES;
    end else begin
      lat = ALU_LAT + 1; sig = ALU_LAT;
    end
    exp_q.push_back({err, d, 16'(lat), 16'(sig)});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_dataA"}, alu_dataA, 32'd0);
    check({tag, "_dataB"}, alu_dataB, 32'd0);
    check({tag, "_signal"}, 32'(alu_signal), 32'(NOP));
    check({tag, "_hilo_valid"}, 32'(dbg_hilo_valid), 32'd0);
  endtask

  // Driver: one full request/response transaction, called on a negedge in IDLE.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [W-1:0] e;
    int lat, sig;
    ref_predict(f, a, b);
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_funct = 6'($urandom_range(0, 63));
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 1;
    sig = 0;
    while (!rsp_valid && lat < 200) begin
      if (alu_signal != NOP) begin
        sig++;
        check("issue_code", 32'(alu_signal), 32'(f));
      end
      check("busy_ready", 32'(req_ready), 32'd0);
      check("busy_flag", 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    check("rsp_latency", 32'(lat), 32'(e[31:16]));
    check("issue_cycles", 32'(sig), 32'(e[15:0]));
    check("rsp_data", rsp_data, e[63:32]);
    check("rsp_err", 32'(rsp_err), 32'(e[64]));
    check("opA_held", alu_dataA, a);
    check("opB_held", alu_dataB, b);
    check("rsp_signal_nop", 32'(alu_signal), 32'(NOP));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, e[63:32]);
      check("hold_err", 32'(rsp_err), 32'(e[64]));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    int seen;

    // Reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(6'd32, 32'd5, 32'd7, 0);            // ADD
    do_op(6'd18, 32'd1, 32'd2, 0);            // MFLO before any DIVU
    do_op(6'd27, 32'd9, 32'd0, 0);            // DIVU by zero
    do_op(6'd16, 32'd0, 32'd0, 0);            // MFHI still invalid
    do_op(6'd27, 32'd100, 32'd7, 0);          // DIVU 100/7
    do_op(6'd16, 32'd0, 32'd0, 0);            // MFHI -> 2
    do_op(6'd18, 32'd0, 32'd0, 0);            // MFLO -> 14
    do_op(6'd34, 32'd3, 32'd5, 5);            // SUB held 5 cycles
    do_op(6'd63, 32'd1, 32'd1, 0);            // illegal
    do_op(6'd27, 32'd50, 32'd0, 1);           // failed DIVU keeps HI/LO
    do_op(6'd16, 32'd0, 32'd0, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = $urandom_range(0, 9);
      if (idx < 9) f = legal_f[idx];
      else begin
        f = 6'($urandom_range(0, 63));
        while (tb_legal(f)) f = 6'($urandom_range(0, 63));
      end
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      do_op(f, a, b, $urandom_range(0, 3));
    end

    // Ensure HI/LO valid, then abandon a divide with reset at accept+10
    do_op(6'd27, 32'd1000, 32'd3, 0);
    check("hilo_before_reset", 32'(dbg_hilo_valid), 32'(ref_hv));
    req_valid = 1'b1;
    req_funct = 6'd27;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_div_signal", 32'(alu_signal), 32'd27);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    ref_hv = 1'b0;
    reset  = 1'b1;
    seen   = 0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abandoned_no_rsp", 32'(seen), 32'd0);
    do_op(6'd16, 32'd0, 32'd0, 0);            // MFHI invalid again after reset
    do_op(6'd37, 32'hF0F0_0000, 32'h0000_0F0F, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
